// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - b_in (mod 2^WIDTH) with borrow_out,
// one full-subtractor cell stepping LSB first, operands and results moved by valid/ready.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic [1:0]       dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high;
   // ready/valid are registered and depend only on state, never combinationally on inputs.

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_next;
   logic             borrow;
   logic [CW-1:0]    count;
   logic             x;
   logic             y;
   logic             d;
   logic             c_next;

   always_comb begin
      x      = a_sr[0];
      y      = b_sr[0];
      d      = x ^ y ^ borrow;
      c_next = (~x & y) | (~(x ^ y) & borrow);
   end

   // Result bits enter at the MSB so the last bit computed lands in position WIDTH-1.
   generate
      if (WIDTH == 1) begin : g_res_one
         assign res_next = d;
      end else begin : g_res_wide
         assign res_next = {d, res_sr[WIDTH-1:1]};
      end
   endgenerate

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         count      <= '0;
         borrow     <= 1'b0;
         a_sr       <= '0;
         b_sr       <= '0;
         res_sr     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr     <= a;
                  b_sr     <= b;
                  borrow   <= b_in;
                  count    <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               borrow <= c_next;
               count  <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) begin
                  diff       <= res_next;
                  borrow_out <= c_next;
                  out_valid  <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               // Returning to IDLE raises in_ready only after this edge.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (WIDTH 8, 4, 1) checked against an
// integer-arithmetic reference for diff/borrow, latency and handshake behaviour.
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   logic       in_valid_v [3];
   logic       out_ready_v[3];
   logic       b_in_v     [3];
   logic [7:0] a_v        [3];
   logic [7:0] b_v        [3];

   logic       in_ready_v [3];
   logic       out_valid_v[3];
   logic       borrow_v   [3];
   logic [7:0] diff_v     [3];
   logic [1:0] dbg_v      [3];

   logic       ir8, ov8, bo8, ir4, ov4, bo4, ir1, ov1, bo1;
   logic [7:0] d8;
   logic [3:0] d4;
   logic [0:0] d1;
   logic [1:0] s8, s4, s1;

   int n_checks = 0;
   int n_pass   = 0;

   serial_subtractor #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(ir8),
      .a(a_v[0]), .b(b_v[0]), .b_in(b_in_v[0]), .out_valid(ov8),
      .out_ready(out_ready_v[0]), .diff(d8), .borrow_out(bo8), .dbg_state(s8)
   );

   serial_subtractor #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(ir4),
      .a(a_v[1][3:0]), .b(b_v[1][3:0]), .b_in(b_in_v[1]), .out_valid(ov4),
      .out_ready(out_ready_v[1]), .diff(d4), .borrow_out(bo4), .dbg_state(s4)
   );

   serial_subtractor #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(ir1),
      .a(a_v[2][0:0]), .b(b_v[2][0:0]), .b_in(b_in_v[2]), .out_valid(ov1),
      .out_ready(out_ready_v[2]), .diff(d1), .borrow_out(bo1), .dbg_state(s1)
   );

   always_comb begin
      in_ready_v[0]  = ir8;  in_ready_v[1]  = ir4;  in_ready_v[2]  = ir1;
      out_valid_v[0] = ov8;  out_valid_v[1] = ov4;  out_valid_v[2] = ov1;
      borrow_v[0]    = bo8;  borrow_v[1]    = bo4;  borrow_v[2]    = bo1;
      diff_v[0]      = d8;   diff_v[1]      = {4'b0, d4};
      diff_v[2]      = {7'b0, d1};
      dbg_v[0]       = s8;   dbg_v[1]       = s4;   dbg_v[2]       = s1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic int wid(input int k);
      return (k == 0) ? 8 : ((k == 1) ? 4 : 1);
   endfunction

   // One full transaction: accept, count latency, compare with reference, hold in DONE, release.
   task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                         input logic bi, input int hold, input bit noisy);
      int         w;
      int         r;
      int         lat;
      int         guard;
      logic [7:0] mk;
      logic [7:0] ed;
      logic       eb;
      w  = wid(k);
      mk = 8'((1 << w) - 1);
      r  = int'(av & mk) - int'(bv & mk) - int'(bi);
      ed = r[7:0] & mk;
      eb = (r < 0);
      guard = 0;
      while (!in_ready_v[k] && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("accept_ready", 32'(in_ready_v[k]), 32'd1);
      a_v[k]         = av;
      b_v[k]         = bv;
      b_in_v[k]      = bi;
      in_valid_v[k]  = 1'b1;
      out_ready_v[k] = 1'b0;
      @(negedge clk);
      in_valid_v[k] = noisy;
      lat = 0;
      while (!out_valid_v[k] && lat < w + 4) begin
         if (noisy) begin
            a_v[k]    = 8'($urandom);
            b_v[k]    = 8'($urandom);
            b_in_v[k] = 1'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      in_valid_v[k] = 1'b0;
      check("latency", 32'(lat), 32'(w));
      check("diff", 32'(diff_v[k]), 32'(ed));
      check("borrow", 32'(borrow_v[k]), 32'(eb));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(out_valid_v[k]), 32'd1);
         check("hold_diff", 32'(diff_v[k]), 32'(ed));
         check("hold_borrow", 32'(borrow_v[k]), 32'(eb));
      end
      out_ready_v[k] = 1'b1;
      @(negedge clk);
      out_ready_v[k] = 1'b0;
      check("post_valid", 32'(out_valid_v[k]), 32'd0);
      check("post_ready", 32'(in_ready_v[k]), 32'd1);
      check("post_diff", 32'(diff_v[k]), 32'(ed));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0; b_in_v[k] = 1'b0;
         a_v[k] = 8'h00; b_v[k] = 8'h00;
      end
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready_v[0]), 32'd1);
      check("rst_out_valid", 32'(out_valid_v[0]), 32'd0);
      check("rst_diff", 32'(diff_v[0]), 32'd0);
      check("rst_borrow", 32'(borrow_v[0]), 32'd0);
      check("rst_state", 32'(dbg_v[0]), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases, including wrap-around and borrow-in.
      run_op(0, 8'h35, 8'h12, 1'b0, 0, 1'b0);
      run_op(0, 8'h00, 8'h01, 1'b0, 0, 1'b0);
      run_op(0, 8'h80, 8'h7F, 1'b1, 0, 1'b0);
      run_op(0, 8'hFF, 8'hFF, 1'b1, 0, 1'b0);
      // Back-pressure in DONE.
      run_op(0, 8'hA5, 8'h3C, 1'b1, 5, 1'b0);

      // Reset after three bits of an operation: nothing from it may surface.
      in_valid_v[0] = 1'b1; a_v[0] = 8'hC3; b_v[0] = 8'h11; b_in_v[0] = 1'b0;
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_in_ready", 32'(in_ready_v[0]), 32'd1);
      check("mid_rst_out_valid", 32'(out_valid_v[0]), 32'd0);
      check("mid_rst_diff", 32'(diff_v[0]), 32'd0);
      check("mid_rst_borrow", 32'(borrow_v[0]), 32'd0);
      repeat (10) @(negedge clk);
      check("mid_rst_no_result", 32'(out_valid_v[0]), 32'd0);
      run_op(0, 8'h10, 8'h01, 1'b0, 0, 1'b0);

      // in_valid held with changing operands while busy.
      for (int i = 0; i < 6; i++)
         run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 2), 1'b1);
      repeat (4) @(negedge clk);
      check("no_extra_result", 32'(out_valid_v[0]), 32'd0);

      // Random WIDTH=8 traffic.
      for (int i = 0; i < 40; i++)
         run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b0);

      // Exhaustive narrow widths.
      for (int av = 0; av < 16; av++)
         for (int bv = 0; bv < 16; bv++)
            for (int bi = 0; bi < 2; bi++)
               run_op(1, 8'(av), 8'(bv), 1'(bi), $urandom_range(0, 2), 1'b0);
      for (int av = 0; av < 2; av++)
         for (int bv = 0; bv < 2; bv++)
            for (int bi = 0; bi < 2; bi++)
               run_op(2, 8'(av), 8'(bv), 1'(bi), $urandom_range(0, 2), 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
